// File: rtl/hdc_assoc_classifier.sv
// Associative-memory classifier for the HDC spam filter: serially accumulates the
// Hamming distances of a query hypervector to the HAM and SPAM class vectors, then labels the query.
module hdc_assoc_classifier #(
    parameter int D      = 2048,
    parameter int CHUNK  = 64,
    parameter int MARGIN = 0,
    localparam int DW    = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  query_hv,
    input  logic [D-1:0]  ham_hv,
    input  logic [D-1:0]  spam_hv,
    output logic          busy,
    output logic          done,
    output logic [1:0]    result,
    output logic [DW-1:0] ham_dist,
    output logic [DW-1:0] spam_dist
);

    localparam int NCHUNK = D / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [D-1:0]    diff_h;
    logic [D-1:0]    diff_s;
    logic [DW-1:0]   acc_h;
    logic [DW-1:0]   acc_s;
    logic            last_chunk;
    logic            ham_wins;
    logic            spam_wins;
    logic [31:0]     acc_h_ext;
    logic [31:0]     acc_s_ext;

    function automatic logic [PW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    // Compare in a wider domain so "dist - MARGIN" can never wrap below zero.
    assign acc_h_ext = 32'(acc_h);
    assign acc_s_ext = 32'(acc_s);
    assign ham_wins  = (acc_h_ext + 32'(MARGIN)) < acc_s_ext;
    assign spam_wins = (acc_s_ext + 32'(MARGIN)) < acc_h_ext;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_chunk) state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the XOR of query with each class vector matters, so the snapshot
    // stores the two difference vectors and shifts them down one chunk per edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 2'b11;
            ham_dist  <= '0;
            spam_dist <= '0;
            cnt       <= '0;
            acc_h     <= '0;
            acc_s     <= '0;
            diff_h    <= '0;
            diff_s    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        diff_h <= query_hv ^ ham_hv;
                        diff_s <= query_hv ^ spam_hv;
                        acc_h  <= '0;
                        acc_s  <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_h  <= acc_h + DW'(popcount(diff_h[CHUNK-1:0]));
                    acc_s  <= acc_s + DW'(popcount(diff_s[CHUNK-1:0]));
                    diff_h <= diff_h >> CHUNK;
                    diff_s <= diff_s >> CHUNK;
                    cnt    <= cnt + CW'(1);
                end
                CMP: begin
                    ham_dist  <= acc_h;
                    spam_dist <= acc_s;
                    if (ham_wins) begin
                        result <= 2'b00;
                    end else if (spam_wins) begin
                        result <= 2'b01;
                    end else begin
                        result <= 2'b11;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_assoc_classifier.sv
// Bench for hdc_assoc_classifier: two instances (MARGIN 0 and 4) share stimulus;
// expected labels/distances come from directed constants or a $countones model.
module tb_hdc_assoc_classifier;

    localparam int D     = 2048;
    localparam int CHUNK = 64;
    localparam int DW    = $clog2(D + 1);
    localparam int W     = 4 + 2 * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [D-1:0]  query_hv = '0;
    logic [D-1:0]  ham_hv = '0;
    logic [D-1:0]  spam_hv = '0;

    logic          busy0, done0, busy4, done4;
    logic [1:0]    result0, result4;
    logic [DW-1:0] ham_dist0, spam_dist0, ham_dist4, spam_dist4;

    int vectors = 0;
    int miscompares = 0;
    // Entry layout: {label at margin 0, label at margin 4, ham_dist, spam_dist}
    logic [W-1:0] exp_q[$];

    hdc_assoc_classifier #(.D(D), .CHUNK(CHUNK), .MARGIN(0)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .query_hv(query_hv), .ham_hv(ham_hv), .spam_hv(spam_hv),
        .busy(busy0), .done(done0), .result(result0),
        .ham_dist(ham_dist0), .spam_dist(spam_dist0)
    );

    hdc_assoc_classifier #(.D(D), .CHUNK(CHUNK), .MARGIN(4)) dut4 (
        .clk(clk), .reset(reset), .start(start),
        .query_hv(query_hv), .ham_hv(ham_hv), .spam_hv(spam_hv),
        .busy(busy4), .done(done4), .result(result4),
        .ham_dist(ham_dist4), .spam_dist(spam_dist4)
    );

    always #5 clk = ~clk;

    function automatic logic [D-1:0] rand_vec();
        logic [D-1:0] v;
        for (int i = 0; i < D / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [D-1:0] flip_mask(input int n);
        logic [D-1:0] m;
        int k;
        int p;
        m = '0;
        k = 0;
        while (k < n) begin
            p = $urandom_range(D - 1, 0);
            if (!m[p]) begin
                m[p] = 1'b1;
                k++;
            end
        end
        return m;
    endfunction

    function automatic logic [1:0] classify(input int hd, input int sd, input int m);
        if (hd + m < sd) return 2'b00;
        if (sd + m < hd) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [W-1:0] mk(input int r0, input int r4, input int hd, input int sd);
        return {2'(r0), 2'(r4), DW'(hd), DW'(sd)};
    endfunction

    function automatic logic [W-1:0] model(input logic [D-1:0] q, input logic [D-1:0] h,
                                           input logic [D-1:0] s);
        int hd;
        int sd;
        hd = $countones(q ^ h);
        sd = $countones(q ^ s);
        return mk(int'(classify(hd, sd, 0)), int'(classify(hd, sd, 4)), hd, sd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, " result m0"},    32'(result0),    32'(e[W-1 -: 2]));
        check({tag, " result m4"},    32'(result4),    32'(e[W-3 -: 2]));
        check({tag, " ham_dist m0"},  32'(ham_dist0),  32'(e[2*DW-1 -: DW]));
        check({tag, " spam_dist m0"}, 32'(spam_dist0), 32'(e[DW-1:0]));
        check({tag, " ham_dist m4"},  32'(ham_dist4),  32'(e[2*DW-1 -: DW]));
        check({tag, " spam_dist m4"}, 32'(spam_dist4), 32'(e[DW-1:0]));
    endtask

    // Drive one start pulse, then scramble the inputs to prove the snapshot.
    task automatic launch(input logic [D-1:0] q, input logic [D-1:0] h,
                          input logic [D-1:0] s, input logic [W-1:0] e);
        @(negedge clk);
        query_hv = q;
        ham_hv   = h;
        spam_hv  = s;
        start    = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy after accept", 32'(busy0), 32'd1);
        query_hv = rand_vec();
        ham_hv   = rand_vec();
        spam_hv  = rand_vec();
    endtask

    task automatic wait_done(input string tag);
        int cycles;
        cycles = 0;
        while (!done0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'd33);
        check({tag, " done m4"}, 32'(done4), 32'd1);
        check({tag, " busy in done"}, 32'(busy0), 32'd0);
        check_result(tag);
        @(negedge clk);
        check({tag, " done falls"}, 32'(done0), 32'd0);
    endtask

    initial begin
        logic [D-1:0] q, h, s, q1;
        int i, ndone, d1, d2, seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset done", 32'(done0), 32'd0);
        check("reset result", 32'(result0), 32'd3);
        check("reset ham_dist", 32'(ham_dist0), 32'd0);
        check("reset spam_dist", 32'(spam_dist0), 32'd0);
        reset = 1'b1;

        // Query equals HAM, SPAM is its complement
        h = rand_vec();
        launch(h, h, ~h, mk(0, 0, 0, 2048));
        wait_done("ham exact");

        // Query equals SPAM, HAM is its complement
        s = rand_vec();
        launch(s, ~s, s, mk(1, 1, 2048, 0));
        wait_done("spam exact");

        // Exact tie at half the dimension
        launch(flip_mask(1024), '0, '1, mk(3, 3, 1024, 1024));
        wait_done("tie 1024");

        // Distances 10/13: decisive at margin 0, inconclusive at margin 4
        h = rand_vec();
        q = h ^ flip_mask(10);
        s = q ^ flip_mask(13);
        launch(q, h, s, mk(0, 3, 10, 13));
        wait_done("margin 10/13");

        // Start held for 40 cycles, query changed mid-run
        h  = rand_vec();
        s  = rand_vec();
        q  = rand_vec();
        q1 = rand_vec();
        @(negedge clk);
        query_hv = q;
        ham_hv   = h;
        spam_hv  = s;
        start    = 1'b1;
        exp_q.push_back(model(q, h, s));
        exp_q.push_back(model(q1, h, s));
        i = 0;
        ndone = 0;
        d1 = 0;
        d2 = 0;
        while (i < 80) begin
            @(negedge clk);
            i++;
            if (i == 5) query_hv = q1;
            if (i == 40) start = 1'b0;
            if (done0) begin
                ndone++;
                if (ndone == 1) d1 = i;
                else d2 = i;
                if (exp_q.size() > 0) check_result("held start");
            end
        end
        check("held start done count", 32'(ndone), 32'd2);
        check("held start first done", 32'(d1), 32'd34);
        check("back-to-back spacing", 32'(d2 - d1), 32'd34);

        // Reset during RUN aborts silently
        h = rand_vec();
        launch(rand_vec(), h, ~h, mk(0, 0, 0, 0));
        void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy0), 32'd0);
        check("abort result", 32'(result0), 32'd3);
        check("abort ham_dist", 32'(ham_dist0), 32'd0);
        check("abort spam_dist", 32'(spam_dist0), 32'd0);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0 || done4) seen++;
        end
        check("no done after abort", 32'(seen), 32'd0);
        q = rand_vec();
        h = rand_vec();
        s = rand_vec();
        launch(q, h, s, model(q, h, s));
        wait_done("after abort");

        // Randomized runs, half of them near-ties to exercise the margin
        for (int n = 0; n < 8; n++) begin
            h = rand_vec();
            if (n % 2 == 0) begin
                q = rand_vec();
                s = rand_vec();
            end else begin
                q = h ^ flip_mask($urandom_range(12, 0));
                s = q ^ flip_mask($urandom_range(12, 0));
            end
            launch(q, h, s, model(q, h, s));
            wait_done("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
